// File: rtl/conv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// conv_ctrl_pkg
// Shared types and sizing helpers for the convolution loop-nest controller.
//   state_e    : controller FSM states
//   stride_e   : run-time stride selection (latched at start)
//   sel_width  : bit width for a select/counter with n distinct values (min 1)
//   nb_passes  : MAC passes per output (input channels / channels per pass)
//   beats      : bus beats per load phase (kernel side * channels per pass)
// -----------------------------------------------------------------------------
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_K  = 3'd1,
        ST_LOAD_I  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_WAIT    = 3'd4,
        ST_DRIVE   = 3'd5
    } state_e;

    typedef enum logic {
        STRIDE_1 = 1'b0,
        STRIDE_2 = 1'b1
    } stride_e;

    // A counter over a single value still needs one bit to exist.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int nb_passes(input int in_channels, input int ch_per_pass);
        return in_channels / ch_per_pass;
    endfunction

    function automatic int beats(input int kernel_size, input int ch_per_pass);
        return kernel_size * ch_per_pass;
    endfunction

endpackage

// File: rtl/loop_counter.sv
// -----------------------------------------------------------------------------
// loop_counter
// Wrap-at-limit counter used for every level of the loop nest.
//   clk, rst_in : clock, synchronous active-high reset
//   clear       : force count to 0 (start of a run)
//   en          : advance by step this cycle
//   step        : increment (1 or 2)
//   limit       : largest value the count may take
//   count       : current value
//   last        : the next advance would pass limit, so it wraps to 0
// -----------------------------------------------------------------------------
module loop_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             clear,
    input  logic             en,
    input  logic [1:0]       step,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    // Two guard bits so count+step never overflows before the limit compare;
    // with stride 2 this also ends the sequence on the largest even value.
    logic [WIDTH+1:0] sum;

    assign sum  = {2'b00, count} + {{WIDTH{1'b0}}, step};
    assign last = (sum > {2'b00, limit});

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst_in || clear) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/conv_loop_ctrl.sv
// -----------------------------------------------------------------------------
// conv_loop_ctrl
// Loop-nest controller for the convolution accelerator. For every output
// (y, x, och) it runs NB_PASSES passes of {kernel load, input load, MAC},
// waits for the accumulator, captures it into the output drain and drives the
// result on the shared buses.
//   clk, rst_in      : clock, synchronous active-high reset
//   start            : launch a run (IDLE only); cfg_stride latched with it
//   con_valid        : host beat valid; con_ready : controller accepts a beat
//   kds_le/_sel      : kernel-store load enable and slot
//   idss_shift/_le_sel : input shift structure load and slot
//   mac_en, acc_clear: MAC pass strobe, clear accumulator on the first pass
//   ods_shift        : capture accumulator into output drain
//   output_valid, output_x/y/ch, driving_cons : result beat on the buses
//   running, done    : run in progress, one-cycle end-of-run pulse
// -----------------------------------------------------------------------------
module conv_loop_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int INPUT_NB_CHANNELS  = 64,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int KERNEL_SIZE        = 3,
    parameter int CH_PER_PASS        = 4,
    parameter int MAC_LATENCY        = 2
) (
    input  logic clk,
    input  logic rst_in,
    input  logic start,
    input  logic cfg_stride,
    input  logic con_valid,
    output logic con_ready,
    output logic kds_le,
    output logic [sel_width(KERNEL_SIZE*CH_PER_PASS)-1:0] kds_le_sel,
    output logic idss_shift,
    output logic [sel_width(KERNEL_SIZE*CH_PER_PASS)-1:0] idss_le_sel,
    output logic mac_en,
    output logic acc_clear,
    output logic ods_shift,
    output logic output_valid,
    output logic [sel_width(FEATURE_MAP_WIDTH)-1:0]  output_x,
    output logic [sel_width(FEATURE_MAP_HEIGHT)-1:0] output_y,
    output logic [sel_width(OUTPUT_NB_CHANNELS)-1:0] output_ch,
    output logic driving_cons,
    output logic running,
    output logic done
);

    localparam int NB_PASSES = nb_passes(INPUT_NB_CHANNELS, CH_PER_PASS);
    localparam int BEATS     = beats(KERNEL_SIZE, CH_PER_PASS);
    localparam int BW        = sel_width(BEATS);
    localparam int PW        = sel_width(NB_PASSES);
    localparam int CW        = sel_width(OUTPUT_NB_CHANNELS);
    localparam int XW        = sel_width(FEATURE_MAP_WIDTH);
    localparam int YW        = sel_width(FEATURE_MAP_HEIGHT);
    localparam int WW        = sel_width(MAC_LATENCY + 1);

    localparam logic [BW-1:0] BEAT_LIMIT = BW'(BEATS - 1);
    localparam logic [PW-1:0] PASS_LIMIT = PW'(NB_PASSES - 1);
    localparam logic [CW-1:0] OCH_LIMIT  = CW'(OUTPUT_NB_CHANNELS - 1);
    localparam logic [XW-1:0] X_LIMIT    = XW'(FEATURE_MAP_WIDTH - 1);
    localparam logic [YW-1:0] Y_LIMIT    = YW'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(MAC_LATENCY);

    state_e          state;
    state_e          next_state;
    stride_e         stride_q;
    logic            running_q;
    logic            done_q;
    logic [WW-1:0]   wait_cnt;

    logic [BW-1:0]   beat_cnt;
    logic [PW-1:0]   pass_cnt;
    logic [CW-1:0]   och_cnt;
    logic [XW-1:0]   x_cnt;
    logic [YW-1:0]   y_cnt;
    logic            beat_last, pass_last, och_last, x_last, y_last;

    logic            run_start;
    logic            loading;
    logic            handshake;
    logic            in_drive;
    logic            x_en, y_en, run_last;
    logic [1:0]      xy_step;

    assign run_start = (state == ST_IDLE) && start;
    assign loading   = (state == ST_LOAD_K) || (state == ST_LOAD_I);
    assign handshake = loading && con_valid;
    assign in_drive  = (state == ST_DRIVE);
    assign x_en      = in_drive && och_last;
    assign y_en      = x_en && x_last;
    assign run_last  = y_en && y_last;
    assign xy_step   = (stride_q == STRIDE_2) ? 2'd2 : 2'd1;

    // Beat index wraps to 0 on the last beat, so it is ready for the next phase.
    loop_counter #(.WIDTH(BW)) u_beat (
        .clk(clk), .rst_in(rst_in), .clear(run_start), .en(handshake),
        .step(2'd1), .limit(BEAT_LIMIT), .count(beat_cnt), .last(beat_last)
    );

    loop_counter #(.WIDTH(PW)) u_pass (
        .clk(clk), .rst_in(rst_in), .clear(run_start), .en(state == ST_COMPUTE),
        .step(2'd1), .limit(PASS_LIMIT), .count(pass_cnt), .last(pass_last)
    );

    loop_counter #(.WIDTH(CW)) u_och (
        .clk(clk), .rst_in(rst_in), .clear(run_start), .en(in_drive),
        .step(2'd1), .limit(OCH_LIMIT), .count(och_cnt), .last(och_last)
    );

    loop_counter #(.WIDTH(XW)) u_x (
        .clk(clk), .rst_in(rst_in), .clear(run_start), .en(x_en),
        .step(xy_step), .limit(X_LIMIT), .count(x_cnt), .last(x_last)
    );

    loop_counter #(.WIDTH(YW)) u_y (
        .clk(clk), .rst_in(rst_in), .clear(run_start), .en(y_en),
        .step(xy_step), .limit(Y_LIMIT), .count(y_cnt), .last(y_last)
    );

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state     <= ST_IDLE;
            stride_q  <= STRIDE_1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state    <= next_state;
            done_q   <= run_last;
            // Counts the MAC latency, then the capture cycle at WAIT_LAST.
            wait_cnt <= ((state == ST_WAIT) && (wait_cnt != WAIT_LAST)) ? wait_cnt + 1'b1 : '0;
            if (run_start) begin
                stride_q  <= stride_e'(cfg_stride);
                running_q <= 1'b1;
            end else if (run_last) begin
                running_q <= 1'b0;
            end
        end
    end

    // Outputs decode the state and counter flops only; kds_le/idss_shift also
    // include con_valid because they must coincide with the accepting beat.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal (no latches).
        next_state   = state;
        con_ready    = 1'b0;
        kds_le       = 1'b0;
        kds_le_sel   = '0;
        idss_shift   = 1'b0;
        idss_le_sel  = '0;
        mac_en       = 1'b0;
        acc_clear    = 1'b0;
        ods_shift    = 1'b0;
        output_valid = 1'b0;
        output_x     = '0;
        output_y     = '0;
        output_ch    = '0;
        driving_cons = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_LOAD_K;
            end
            ST_LOAD_K: begin
                con_ready  = 1'b1;
                kds_le     = con_valid;
                kds_le_sel = beat_cnt;
                if (con_valid && beat_last) next_state = ST_LOAD_I;
            end
            ST_LOAD_I: begin
                con_ready   = 1'b1;
                idss_shift  = con_valid;
                idss_le_sel = beat_cnt;
                if (con_valid && beat_last) next_state = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                mac_en     = 1'b1;
                acc_clear  = (pass_cnt == '0);
                next_state = pass_last ? ST_WAIT : ST_LOAD_K;
            end
            ST_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    ods_shift  = 1'b1;
                    next_state = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                output_valid = 1'b1;
                driving_cons = 1'b1;
                output_x     = x_cnt;
                output_y     = y_cnt;
                output_ch    = och_cnt;
                next_state   = run_last ? ST_IDLE : ST_LOAD_K;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign running = running_q;
    assign done    = done_q;

endmodule
